// File: rtl/ram_responder_if.sv
//==============================================================================
// Interface : ram_responder_if
// Purpose   : CPU-to-memory MOV/MOC request bus (MAR/MDR side to memory side)
// Revision  : 1.0  initial release
//==============================================================================
`default_nettype none

interface ram_responder_if;
  logic        MOV;
  logic        R_W;
  logic [1:0]  size;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MOC;
  logic        ERR;

  modport master (
    output MOV, R_W, size, address, data_in,
    input  data_out, MOC, ERR
  );

  modport slave (
    input  MOV, R_W, size, address, data_in,
    output data_out, MOC, ERR
  );
endinterface

`default_nettype wire

// File: rtl/ram_responder.sv
//==============================================================================
// Module    : ram_responder
// Purpose   : Byte-addressed big-endian RAM answering MOV requests with MOC
//             after a fixed number of wait states; flags misaligned/reserved.
// Revision  : 1.0  initial release
//==============================================================================
`default_nettype none

module ram_responder #(
  parameter int DEPTH_BYTES = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         clr,
  ram_responder_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] c_wait_last = 4'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_enter_ack;
  logic [3:0]          r_cnt;
  logic                r_rw;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_dout;
  logic                r_err;
  logic                r_moc;
  logic [7:0]          r_mem [DEPTH_BYTES];

  logic [ADDR_W-1:0]   w_a1;
  logic [ADDR_W-1:0]   w_a2;
  logic [ADDR_W-1:0]   w_a3;
  logic                w_err;
  logic                w_commit;
  logic [31:0]         w_rdata;
  logic                w_unused_addr;

  assign w_unused_addr = ^bus.address[31:ADDR_W];

  assign w_a1 = r_addr + ADDR_W'(1);
  assign w_a2 = r_addr + ADDR_W'(2);
  assign w_a3 = r_addr + ADDR_W'(3);

  assign w_err = (r_size == 2'b11) ||
                 ((r_size == 2'b01) && r_addr[0]) ||
                 ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));

  assign w_commit = w_enter_ack && !r_rw && !w_err;

  always_comb begin
    w_rdata = 32'd0;
    case (r_size)
      2'b00:   w_rdata = {24'd0, r_mem[r_addr]};
      2'b01:   w_rdata = {16'd0, r_mem[r_addr], r_mem[w_a1]};
      2'b10:   w_rdata = {r_mem[r_addr], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
      default: w_rdata = 32'd0;
    endcase
  end

  // WAIT always lasts WAIT_CYCLES+1 edges so MOC rises WAIT_CYCLES+1 edges
  // after the accepting edge, including the zero-wait configuration.
  always_comb begin
    w_state_nxt = r_state;
    w_enter_ack = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.MOV) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.MOV) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_wait_last) begin
          w_state_nxt = S_ACK;
          w_enter_ack = 1'b1;
        end
      end
      S_ACK: begin
        if (!bus.MOV) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_dout  <= 32'd0;
      r_err   <= 1'b0;
      r_moc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_moc   <= (w_state_nxt == S_ACK);
      if (r_state == S_WAIT) r_cnt <= r_cnt + 4'd1;
      else                   r_cnt <= 4'd0;
      if ((r_state == S_IDLE) && bus.MOV) begin
        r_rw    <= bus.R_W;
        r_size  <= bus.size;
        r_addr  <= bus.address[ADDR_W-1:0];
        r_wdata <= bus.data_in;
      end
      if (w_enter_ack) begin
        r_err <= w_err;
        if (w_err)     r_dout <= 32'd0;
        else if (r_rw) r_dout <= w_rdata;
      end else if ((r_state == S_ACK) && !bus.MOV) begin
        r_err <= 1'b0;
      end
    end
  end

  // Storage is deliberately outside the reset domain: contents survive clr.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      case (r_size)
        2'b00: r_mem[r_addr] <= r_wdata[7:0];
        2'b01: begin
          r_mem[r_addr] <= r_wdata[15:8];
          r_mem[w_a1]   <= r_wdata[7:0];
        end
        2'b10: begin
          r_mem[r_addr] <= r_wdata[31:24];
          r_mem[w_a1]   <= r_wdata[23:16];
          r_mem[w_a2]   <= r_wdata[15:8];
          r_mem[w_a3]   <= r_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out = r_dout;
  assign bus.MOC      = r_moc;
  assign bus.ERR      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
//==============================================================================
// Module    : tb_ram_responder
// Purpose   : Scoreboard bench for ram_responder (2 wait states, plus 0-wait).
// Revision  : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ram_responder;

  logic clk;
  logic clr;

  ram_responder_if bus();
  ram_responder_if bus0();

  ram_responder #(.DEPTH_BYTES(512), .ADDR_W(9), .WAIT_CYCLES(2)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  ram_responder #(.DEPTH_BYTES(512), .ADDR_W(9), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .clr (clr),
    .bus (bus0.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_moc = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops one expectation per MOC rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.MOC && !prev_moc) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_moc: data_out=%h ERR=%b with no request pending",
                 bus.data_out, bus.ERR);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.data_out !== e.data || bus.ERR !== e.err) begin
          errors++;
          $display("FAIL response: got data_out=%h ERR=%b expected data_out=%h ERR=%b",
                   bus.data_out, bus.ERR, e.data, e.err);
        end
      end
    end
    prev_moc = bus.MOC;
  end

  task automatic req(input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err);
    int  n;
    bit  got;
    exp_t e;
    e.data = exp_data;
    e.err  = exp_err;
    q.push_back(e);
    @(negedge clk);
    bus.MOV = 1'b1; bus.R_W = rw; bus.size = sz; bus.address = addr; bus.data_in = wd;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.MOC) got = 1'b1;
      // Scramble inputs after acceptance; the latched request must be used.
      if (n == 1 && !got) begin
        @(negedge clk);
        bus.address = ~addr; bus.data_in = ~wd; bus.size = ~sz;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL moc_timeout: no MOC after %0d edges, required 4", n);
    end else begin
      chk("latency_edges", 32'(n), 32'd4);
    end
    @(negedge clk);
    bus.MOV = 1'b0;
    @(posedge clk); #1;
    chk("moc_drop", {31'd0, bus.MOC}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    clr = 1'b0;
    bus.MOV = 1'b0; bus.R_W = 1'b0; bus.size = 2'b00; bus.address = 32'd0; bus.data_in = 32'd0;
    bus0.MOV = 1'b0; bus0.R_W = 1'b0; bus0.size = 2'b00; bus0.address = 32'd0; bus0.data_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_moc", {31'd0, bus.MOC}, 32'd0);
    chk("reset_err", {31'd0, bus.ERR}, 32'd0);
    chk("reset_data_out", bus.data_out, 32'd0);
    chk("reset_moc_0wait", {31'd0, bus0.MOC}, 32'd0);
    @(negedge clk); clr = 1'b1;

    req(1'b0, 2'b10, 32'h10, 32'h11223344, 32'h0, 1'b0);

    // Reset in the middle of WAIT for a write to 0x10.
    @(negedge clk);
    bus.MOV = 1'b1; bus.R_W = 1'b0; bus.size = 2'b10; bus.address = 32'h10; bus.data_in = 32'hAAAAAAAA;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (bus.MOC) seen = 1'b1; end
    @(negedge clk); clr = 1'b0;
    @(negedge clk); bus.MOV = 1'b0;
    @(negedge clk); clr = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (bus.MOC) seen = 1'b1; end
    chk("reset_midwait_no_moc", {31'd0, seen}, 32'd0);
    req(1'b1, 2'b10, 32'h10, 32'h0, 32'h11223344, 1'b0);

    req(1'b0, 2'b10, 32'h20, 32'hDEADBEEF, 32'h11223344, 1'b0);
    req(1'b1, 2'b00, 32'h20, 32'h0, 32'h000000DE, 1'b0);
    req(1'b1, 2'b00, 32'h21, 32'h0, 32'h000000AD, 1'b0);
    req(1'b1, 2'b00, 32'h22, 32'h0, 32'h000000BE, 1'b0);
    req(1'b1, 2'b00, 32'h23, 32'h0, 32'h000000EF, 1'b0);

    req(1'b1, 2'b01, 32'h21, 32'h0, 32'h0, 1'b1);
    req(1'b1, 2'b11, 32'h20, 32'h0, 32'h0, 1'b1);
    req(1'b0, 2'b01, 32'h21, 32'h1234, 32'h0, 1'b1);
    req(1'b1, 2'b01, 32'h22, 32'h0, 32'h0000BEEF, 1'b0);
    req(1'b1, 2'b10, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0);

    // Abort a byte write to 0x30 during WAIT.
    req(1'b0, 2'b00, 32'h30, 32'h99, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    bus.MOV = 1'b1; bus.R_W = 1'b0; bus.size = 2'b00; bus.address = 32'h30; bus.data_in = 32'h55;
    @(posedge clk);
    @(negedge clk); bus.MOV = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus.MOC) seen = 1'b1; end
    chk("abort_no_moc", {31'd0, seen}, 32'd0);
    req(1'b1, 2'b00, 32'h30, 32'h0, 32'h00000099, 1'b0);

    req(1'b0, 2'b10, 32'd520, 32'h01020304, 32'h00000099, 1'b0);
    req(1'b1, 2'b10, 32'h08, 32'h0, 32'h01020304, 1'b0);
    req(1'b0, 2'b10, 32'd508, 32'hCAFEF00D, 32'h01020304, 1'b0);
    req(1'b1, 2'b10, 32'd508, 32'h0, 32'hCAFEF00D, 1'b0);
    req(1'b1, 2'b01, 32'd510, 32'h0, 32'h0000F00D, 1'b0);

    // Zero-wait instance: MOC one edge after the accepting edge.
    @(negedge clk);
    bus0.MOV = 1'b1; bus0.R_W = 1'b0; bus0.size = 2'b10; bus0.address = 32'h40; bus0.data_in = 32'hA5A55A5A;
    n = 0;
    while (!bus0.MOC && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency_0wait_write", 32'(n), 32'd2);
    @(negedge clk); bus0.MOV = 1'b0;
    @(negedge clk);
    bus0.MOV = 1'b1; bus0.R_W = 1'b1; bus0.size = 2'b10; bus0.address = 32'h40;
    n = 0;
    while (!bus0.MOC && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency_0wait_read", 32'(n), 32'd2);
    chk("data_0wait_read", bus0.data_out, 32'hA5A55A5A);
    chk("err_0wait_read", {31'd0, bus0.ERR}, 32'd0);
    @(negedge clk); bus0.MOV = 1'b0;

    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
